// File: rtl/i2c_slave_regs.sv
// I2C target with a small register file, run from the system clock by sampling SCL/SDA.
// The bus side and a host port share the registers; a bus write wins a same-index collision.
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDRESS = 7'h68,
  parameter int         NUM_REGS      = 16,
  localparam int        PW            = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          sda_out,
  input  logic [PW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  input  logic          host_we,
  output logic [7:0]    host_rdata,
  output logic          wr_strobe,
  output logic [PW-1:0] wr_index,
  output logic          busy,
  output logic [2:0]    status
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    RX_BYTE  = 3'd3,
    RX_ACK   = 3'd4,
    TX_BYTE  = 3'd5,
    TX_ACK   = 3'd6,
    IGNORE   = 3'd7
  } state_t;

  state_t        state, state_d;
  logic [3:0]    bit_cnt, bit_cnt_d;
  logic [7:0]    shift, shift_d;
  logic          sda_d, busy_d;
  logic [PW-1:0] ptr, ptr_d;
  logic          first, first_d;
  logic          rw, rw_d;
  logic          bus_we;
  logic [7:0]    regs [NUM_REGS];

  logic scl_s1, scl_s2, scl_s3;
  logic sda_s1, sda_s2, sda_s3;
  logic scl_rise, scl_fall, start, stop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {scl_s1, scl_s2, scl_s3} <= 3'b111;
      {sda_s1, sda_s2, sda_s3} <= 3'b111;
    end else begin
      {scl_s1, scl_s2, scl_s3} <= {scl_in, scl_s1, scl_s2};
      {sda_s1, sda_s2, sda_s3} <= {sda_in, sda_s1, sda_s2};
    end
  end

  assign scl_rise = scl_s2 & ~scl_s3;
  assign scl_fall = ~scl_s2 & scl_s3;
  assign start    = scl_s2 & scl_s3 & sda_s3 & ~sda_s2;
  assign stop     = scl_s2 & scl_s3 & ~sda_s3 & sda_s2;
  assign status   = state;

  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    shift_d   = shift;
    sda_d     = sda_out;
    ptr_d     = ptr;
    first_d   = first;
    rw_d      = rw;
    busy_d    = busy;
    bus_we    = 1'b0;
    // START/STOP override any bit activity seen in the same clock.
    if (start) begin
      sda_d     = 1'b1;
      bit_cnt_d = 4'd0;
      state_d   = ADDR;
    end else if (stop) begin
      sda_d   = 1'b1;
      busy_d  = 1'b0;
      state_d = IDLE;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise) begin
            shift_d   = {shift[6:0], sda_s2};
            bit_cnt_d = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            if (shift[7:1] == SLAVE_ADDRESS) begin
              sda_d   = 1'b0;
              rw_d    = shift[0];
              busy_d  = 1'b1;
              state_d = ADDR_ACK;
            end else begin
              busy_d  = 1'b0;
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (!rw) begin
              sda_d   = 1'b1;
              first_d = 1'b1;
              state_d = RX_BYTE;
            end else begin
              shift_d = regs[ptr];
              sda_d   = regs[ptr][7];
              state_d = TX_BYTE;
            end
          end
        end
        RX_BYTE: begin
          if (scl_rise) begin
            shift_d   = {shift[6:0], sda_s2};
            bit_cnt_d = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            sda_d     = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = RX_ACK;
            // The first byte after the address selects the register pointer.
            if (first) begin
              ptr_d   = shift[PW-1:0];
              first_d = 1'b0;
            end else begin
              bus_we = 1'b1;
              ptr_d  = ptr + 1'b1;
            end
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            sda_d   = 1'b1;
            state_d = RX_BYTE;
          end
        end
        TX_BYTE: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_d     = 1'b1;
              bit_cnt_d = 4'd0;
              ptr_d     = ptr + 1'b1;
              state_d   = TX_ACK;
            end else begin
              sda_d   = shift[6];
              shift_d = {shift[6:0], 1'b0};
            end
          end
        end
        TX_ACK: begin
          if (scl_rise && sda_s2) begin
            state_d = IGNORE;
          end else if (scl_fall) begin
            shift_d   = regs[ptr];
            sda_d     = regs[ptr][7];
            bit_cnt_d = 4'd0;
            state_d   = TX_BYTE;
          end
        end
        IGNORE:  sda_d = 1'b1;
        default: sda_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      shift     <= 8'd0;
      sda_out   <= 1'b1;
      ptr       <= '0;
      first     <= 1'b0;
      rw        <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_index  <= '0;
    end else begin
      state     <= state_d;
      bit_cnt   <= bit_cnt_d;
      shift     <= shift_d;
      sda_out   <= sda_d;
      ptr       <= ptr_d;
      first     <= first_d;
      rw        <= rw_d;
      busy      <= busy_d;
      wr_strobe <= bus_we;
      if (bus_we) wr_index <= ptr;
    end
  end

  // Host writes first so a bus commit to the same index overrides it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'd0;
      host_rdata <= 8'd0;
    end else begin
      if (host_we) regs[host_addr] <= host_wdata;
      if (bus_we)  regs[ptr]       <= shift;
      host_rdata <= regs[host_addr];
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: bus-master driver tasks, passive bus/strobe/host monitors
// popping expected values from queues, and a final report.
module tb_i2c_slave_regs;

  localparam int Q = 4;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_out;
  logic [3:0] host_addr = 4'd0;
  logic [7:0] host_wdata = 8'd0;
  logic       host_we = 1'b0;
  logic [7:0] host_rdata;
  logic       wr_strobe;
  logic [3:0] wr_index;
  logic       busy;
  logic [2:0] status;

  assign sda_bus = sda_m & sda_out;

  i2c_slave_regs dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .scl_in     (scl_m),
    .sda_in     (sda_bus),
    .sda_out    (sda_out),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_we    (host_we),
    .host_rdata (host_rdata),
    .wr_strobe  (wr_strobe),
    .wr_index   (wr_index),
    .busy       (busy),
    .status     (status)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [8:0] frame_q[$];
  logic [3:0] wr_q[$];
  logic [7:0] host_q[$];

  logic       hrd_req = 1'b0;
  logic       quiet_watch = 1'b0;
  int         quiet_viol = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus monitor: decodes START/STOP and 9-bit frames {data, ack} from the wire.
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [8:0] mon_frame = 9'd0;
  logic [8:0] mon_exp;

  always @(posedge clk) begin
    #1;
    if (scl_m && prev_scl && prev_sda && !sda_bus) begin
      mon_active = 1'b1;
      mon_cnt    = 0;
    end else if (scl_m && prev_scl && !prev_sda && sda_bus) begin
      mon_active = 1'b0;
    end else if (scl_m && !prev_scl && mon_active) begin
      mon_frame = {mon_frame[7:0], sda_bus};
      mon_cnt++;
      if (mon_cnt == 9) begin
        mon_cnt = 0;
        if (frame_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_frame: got unexpected frame %0h", mon_frame);
        end else begin
          mon_exp = frame_q.pop_front();
          chk("bus_frame", {7'd0, mon_frame}, {7'd0, mon_exp});
        end
      end
    end
    prev_scl = scl_m;
    prev_sda = sda_bus;
  end

  always @(posedge clk) begin
    #1;
    if (reset_n && wr_strobe) begin
      if (wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_strobe: got unexpected pulse index %0h", wr_index);
      end else begin
        chk("wr_index", {12'd0, wr_index}, {12'd0, wr_q.pop_front()});
      end
    end
    if (hrd_req) begin
      if (host_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL host_rdata: no expectation queued, got %0h", host_rdata);
      end else begin
        chk("host_rdata", {8'd0, host_rdata}, {8'd0, host_q.pop_front()});
      end
    end
    if (quiet_watch && (sda_out !== 1'b1 || busy !== 1'b0)) quiet_viol++;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_out(input logic b, input logic hook, input logic [3:0] ha, input logic [7:0] hd);
    sda_m = b;
    wait_clks(Q);
    scl_m = 1'b1;
    wait_clks(H);
    scl_m = 1'b0;
    if (hook) begin
      // Lands host_we on the same clock as the target's commit of this byte.
      wait_clks(2);
      host_addr  = ha;
      host_wdata = hd;
      host_we    = 1'b1;
      wait_clks(1);
      host_we = 1'b0;
      wait_clks(Q - 3);
    end else begin
      wait_clks(Q);
    end
  endtask

  task automatic send_byte_h(input logic [7:0] b, input logic ack_exp, input logic hook,
                             input logic [3:0] ha, input logic [7:0] hd);
    frame_q.push_back({b, ack_exp});
    for (int i = 7; i >= 0; i--) bit_out(b[i], hook && (i == 0), ha, hd);
    bit_out(1'b1, 1'b0, 4'd0, 8'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ack_exp);
    send_byte_h(b, ack_exp, 1'b0, 4'd0, 8'd0);
  endtask

  task automatic recv_byte(input logic [7:0] exp, input logic mack);
    frame_q.push_back({exp, mack});
    for (int i = 0; i < 8; i++) bit_out(1'b1, 1'b0, 4'd0, 8'd0);
    bit_out(mack, 1'b0, 4'd0, 8'd0);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wait_clks(Q);
    scl_m = 1'b1;
    wait_clks(H);
    sda_m = 1'b0;
    wait_clks(H);
    scl_m = 1'b0;
    wait_clks(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_clks(Q);
    scl_m = 1'b1;
    wait_clks(H);
    sda_m = 1'b1;
    wait_clks(H);
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    host_addr  = a;
    host_wdata = d;
    host_we    = 1'b1;
    wait_clks(1);
    host_we = 1'b0;
  endtask

  task automatic host_read(input logic [3:0] a, input logic [7:0] exp);
    host_addr = a;
    host_q.push_back(exp);
    hrd_req = 1'b1;
    wait_clks(1);
    hrd_req = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    wait_clks(2);
    chk("rst_sda_out", {15'd0, sda_out}, 16'd1);
    chk("rst_host_rdata", {8'd0, host_rdata}, 16'd0);
    chk("rst_wr_strobe", {15'd0, wr_strobe}, 16'd0);
    chk("rst_wr_index", {12'd0, wr_index}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_status", {13'd0, status}, 16'd0);
    reset_n = 1'b1;
    wait_clks(4);

    // Write 0xAA, 0x55 starting at register 3
    i2c_start();
    send_byte(8'hD0, 1'b0);
    chk("busy_after_addr", {15'd0, busy}, 16'd1);
    send_byte(8'h03, 1'b0);
    wr_q.push_back(4'd3);
    send_byte(8'hAA, 1'b0);
    wr_q.push_back(4'd4);
    send_byte(8'h55, 1'b0);
    chk("wr_index_last", {12'd0, wr_index}, 16'd4);
    chk("busy_before_stop", {15'd0, busy}, 16'd1);
    i2c_stop();
    wait_clks(4);
    chk("busy_after_stop", {15'd0, busy}, 16'd0);
    chk("status_after_stop", {13'd0, status}, 16'd0);
    host_read(4'd3, 8'hAA);
    host_read(4'd4, 8'h55);

    // Pointer persists at 5 for a read with no pointer write
    host_write(4'd5, 8'h3C);
    i2c_start();
    send_byte(8'hD1, 1'b0);
    recv_byte(8'h3C, 1'b1);
    i2c_stop();

    // Repeated-START read across the pointer wrap
    host_write(4'd14, 8'h11);
    host_write(4'd15, 8'h22);
    host_write(4'd0, 8'hE7);
    i2c_start();
    send_byte(8'hD0, 1'b0);
    send_byte(8'h0E, 1'b0);
    i2c_start();
    send_byte(8'hD1, 1'b0);
    recv_byte(8'h11, 1'b0);
    recv_byte(8'h22, 1'b0);
    recv_byte(8'hE7, 1'b1);
    chk("sda_after_nack", {15'd0, sda_out}, 16'd1);
    chk("status_after_nack", {13'd0, status}, 16'd7);
    i2c_stop();
    wait_clks(4);
    chk("busy_after_read", {15'd0, busy}, 16'd0);

    // Address mismatch is silent
    quiet_watch = 1'b1;
    i2c_start();
    send_byte(8'hA0, 1'b1);
    chk("status_mismatch", {13'd0, status}, 16'd7);
    send_byte(8'h00, 1'b1);
    i2c_stop();
    wait_clks(2);
    quiet_watch = 1'b0;
    chk("mismatch_quiet", quiet_viol[15:0], 16'd0);
    host_read(4'd0, 8'hE7);
    host_read(4'd3, 8'hAA);

    // Same-clock host/bus collisions
    i2c_start();
    send_byte(8'hD0, 1'b0);
    send_byte(8'h06, 1'b0);
    wr_q.push_back(4'd6);
    send_byte_h(8'h99, 1'b0, 1'b1, 4'd6, 8'h77);
    i2c_stop();
    host_read(4'd6, 8'h99);
    i2c_start();
    send_byte(8'hD0, 1'b0);
    send_byte(8'h06, 1'b0);
    wr_q.push_back(4'd6);
    send_byte_h(8'h99, 1'b0, 1'b1, 4'd7, 8'h77);
    i2c_stop();
    host_read(4'd6, 8'h99);
    host_read(4'd7, 8'h77);

    // Reset during bit 4 of a data byte
    i2c_start();
    send_byte(8'hD0, 1'b0);
    send_byte(8'h0A, 1'b0);
    frame_q.push_back({8'hF0, 1'b1});
    for (int i = 0; i < 4; i++) bit_out(1'b1, 1'b0, 4'd0, 8'd0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_sda_out", {15'd0, sda_out}, 16'd1);
    chk("mid_rst_busy", {15'd0, busy}, 16'd0);
    chk("mid_rst_status", {13'd0, status}, 16'd0);
    wait_clks(3);
    reset_n = 1'b1;
    wait_clks(2);
    for (int i = 0; i < 4; i++) bit_out(1'b0, 1'b0, 4'd0, 8'd0);
    bit_out(1'b1, 1'b0, 4'd0, 8'd0);
    send_byte(8'hD0, 1'b1);
    chk("post_rst_status", {13'd0, status}, 16'd0);
    for (int i = 0; i < 16; i++) host_read(i[3:0], 8'h00);
    host_write(4'd0, 8'hC3);
    i2c_start();
    send_byte(8'hD0, 1'b0);
    i2c_start();
    send_byte(8'hD1, 1'b0);
    recv_byte(8'hC3, 1'b1);
    i2c_stop();

    // Master-style loopback: write 0x5A to register 2, read it back
    i2c_start();
    send_byte(8'hD0, 1'b0);
    send_byte(8'h02, 1'b0);
    wr_q.push_back(4'd2);
    send_byte(8'h5A, 1'b0);
    i2c_stop();
    i2c_start();
    send_byte(8'hD0, 1'b0);
    send_byte(8'h02, 1'b0);
    i2c_start();
    send_byte(8'hD1, 1'b0);
    recv_byte(8'h5A, 1'b1);
    i2c_stop();

    wait_clks(20);
    chk("frames_left", frame_q.size(), 16'd0);
    chk("wr_left", wr_q.size(), 16'd0);
    chk("host_left", host_q.size(), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
